dram_arbiter: RTL

DRAM_ARBITER -- requirements
Module: dram_arbiter

---
 rtl/dram_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/dram_arbiter.sv
// Two-port (CPU m0, DMA m1) arbiter in front of a single-port synchronous RAM.
// Define DRAM_ARB_RR_EN for round-robin contention; default is fixed priority with starve guard.
module dram_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 8,
  parameter int LOCK_MAX   = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clk_en,
  input  logic              i_m0_req,
  input  logic              i_m0_we,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_wdata,
  output logic              o_m0_gnt,
  output logic              o_m0_rvalid,
  output logic [DATA_W-1:0] o_m0_rdata,
  input  logic              i_m1_req,
  input  logic              i_m1_we,
  input  logic              i_m1_lock,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_wdata,
  output logic              o_m1_gnt,
  output logic              o_m1_rvalid,
  output logic [DATA_W-1:0] o_m1_rdata,
  output logic              o_ram_cs,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata
);

  typedef enum logic {ARB, LOCK1} state_t;

  localparam logic [7:0] LIM8 = 8'(STARVE_LIM);
  localparam logic [3:0] LMAX = 4'(LOCK_MAX);

  state_t            state;
  logic [3:0]        lock_cnt;
  logic [7:0]        starve;
  logic              m0_prio;
  logic              resume;
  logic              pend0, pend1;
  logic [DATA_W-1:0] hold0, hold1;
`ifdef DRAM_ARB_RR_EN
  logic              last_m1;
`endif

  logic lk, prio0, pick1, g0, g1;

  assign lk    = i_m1_req & i_m1_lock;
  assign prio0 = m0_prio | (state == LOCK1);
`ifdef DRAM_ARB_RR_EN
  assign pick1 = ~last_m1;
`else
  assign pick1 = (starve == LIM8);
`endif

  // resume lets a burst cut short by LOCK_MAX continue after m0's one slot
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (i_clk_en && !i_rst) begin
      if (state == LOCK1 && lk) begin
        g1 = 1'b1;
      end else if (i_m0_req && i_m1_req) begin
        g1 = ~prio0 & ((resume & lk) | pick1);
        g0 = ~g1;
      end else begin
        g0 = i_m0_req;
        g1 = i_m1_req;
      end
    end
  end

  assign o_m0_gnt    = g0;
  assign o_m1_gnt    = g1;
  assign o_ram_cs    = g0 | g1;
  assign o_ram_we    = g1 ? i_m1_we : (g0 & i_m0_we);
  assign o_ram_addr  = g1 ? i_m1_addr : i_m0_addr;
  assign o_ram_wdata = g1 ? i_m1_wdata : i_m0_wdata;

  assign o_m0_rvalid = pend0 & i_clk_en & ~i_rst;
  assign o_m1_rvalid = pend1 & i_clk_en & ~i_rst;
  assign o_m0_rdata  = o_m0_rvalid ? i_ram_rdata : hold0;
  assign o_m1_rdata  = o_m1_rvalid ? i_ram_rdata : hold1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ARB;
      lock_cnt <= '0;
      starve   <= '0;
      m0_prio  <= 1'b0;
      resume   <= 1'b0;
      pend0    <= 1'b0;
      pend1    <= 1'b0;
      hold0    <= '0;
      hold1    <= '0;
`ifdef DRAM_ARB_RR_EN
      last_m1  <= 1'b1;
`endif
    end else if (i_clk_en) begin
      pend0 <= g0 & ~i_m0_we;
      pend1 <= g1 & ~i_m1_we;
      if (pend0) hold0 <= i_ram_rdata;
      if (pend1) hold1 <= i_ram_rdata;
`ifdef DRAM_ARB_RR_EN
      if (g0 || g1) last_m1 <= g1;
`endif
      if (g1)
        starve <= '0;
      else if (i_m1_req && starve < LIM8)
        starve <= starve + 8'd1;
      m0_prio <= 1'b0;
      if (g1 || !lk) resume <= 1'b0;
      unique case (state)
        ARB: begin
          if (g1 && i_m1_lock) begin
            if (LOCK_MAX > 1) begin
              state    <= LOCK1;
              lock_cnt <= 4'd1;
            end else begin
              m0_prio <= 1'b1;
              resume  <= 1'b1;
            end
          end
        end
        LOCK1: begin
          if (lk && (lock_cnt + 4'd1) < LMAX) begin
            lock_cnt <= lock_cnt + 4'd1;
          end else begin
            state    <= ARB;
            lock_cnt <= '0;
            m0_prio  <= 1'b1;
            resume   <= lk;
          end
        end
      endcase
    end
  end

endmodule
